// File: rtl/mat_result_writer.sv
// Captures MAC results on the controller strobe and writes them to consecutive result RAM addresses.
// Latency: a strobe in cycle t with an empty FIFO gives wr_en in cycle t+1; done follows the last commit by 2 cycles.
// Backpressure: wr_ready low holds the write port stable and the 4-entry FIFO absorbs results; a push into a full FIFO with no pop is dropped and flagged.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start                 level; begins a collection when seen high in IDLE, must drop to leave DONE
//   wire_out, mac_in      one-cycle result strobe and the MAC result it qualifies
//   wr_ready              RAM accepts the presented write this cycle
//   wr_en/wr_addr/wr_data write request, address and data (FIFO head)
//   result_count          writes committed in the current/last operation
//   busy, done            status: COLLECT or DRAIN / DONE
//   overflow              sticky, set when a result is dropped
module mat_result_writer #(
  parameter int DATA_W    = 19,
  parameter int ADDR_W    = 5,
  parameter int N_RESULTS = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              wire_out,
  input  logic [DATA_W-1:0] mac_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   result_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LAST_CAP = (ADDR_W+1)'(N_RESULTS - 1);

  state_t state, state_nxt;

  // Result FIFO: 4 entries, power-of-two so the 2-bit pointers wrap naturally.
  logic [DATA_W-1:0] fifo_mem [4];
  logic [1:0]        rd_ptr, wr_ptr;
  logic [2:0]        fifo_cnt;
  logic              fifo_full, fifo_empty;

  logic [ADDR_W:0]   cap_cnt;
  logic              active, op_start, fifo_push, push_ok, commit, drop, last_cap;

  assign active     = (state == S_COLLECT) || (state == S_DRAIN);
  assign op_start   = (state == S_IDLE) && start;
  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);

  assign wr_en      = active && !fifo_empty;
  assign wr_data    = fifo_mem[rd_ptr];
  assign commit     = wr_en && wr_ready;

  // Only COLLECT listens to the strobe. A full FIFO still takes the push
  // when the head is leaving in the same cycle.
  assign fifo_push  = (state == S_COLLECT) && wire_out;
  assign push_ok    = fifo_push && (!fifo_full || commit);
  assign drop       = fifo_push && fifo_full && !commit;
  // Dropped results still count as captured so the operation always ends.
  assign last_cap   = fifo_push && (cap_cnt == LAST_CAP);

  assign busy = active;
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_COLLECT;
      S_COLLECT: if (last_cap) state_nxt = S_DRAIN;
      // wr_en is exactly "FIFO not empty" here, so empty means nothing pending.
      S_DRAIN:   if (fifo_empty) state_nxt = S_DONE;
      S_DONE:    if (!start) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (op_start) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= mac_in;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (commit) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push_ok, commit})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr      <= '0;
      result_count <= '0;
      cap_cnt      <= '0;
      overflow     <= 1'b0;
    end else if (op_start) begin
      wr_addr      <= '0;
      result_count <= '0;
      cap_cnt      <= '0;
      overflow     <= 1'b0;
    end else begin
      if (commit) begin
        // Wraps to 0 after the final commit when N_RESULTS = 2^ADDR_W.
        wr_addr      <= wr_addr + 1'b1;
        result_count <= result_count + 1'b1;
      end
      if (fifo_push) begin
        cap_cnt <= cap_cnt + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mat_result_writer.sv
module tb_mat_result_writer;

  localparam int DATA_W = 19;
  localparam int ADDR_W = 5;
  localparam int N      = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              wire_out;
  logic [DATA_W-1:0] mac_in;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W:0]   result_count;
  logic              busy;
  logic              done;
  logic              overflow;

  mat_result_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_RESULTS(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wire_out(wire_out),
    .mac_in(mac_in), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .result_count(result_count), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // Reference model of one operation, in terms of the behaviour only:
  // results in flight, how many were captured/accepted/written/dropped.
  bit  m_op, m_collect, m_last_commit;
  int  m_cap, m_occ, m_acc, m_commits, m_drops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model predicts what the coming edge does.
  task automatic cycle(input bit strobe, input logic [DATA_W-1:0] d, input bit rdy);
    bit cm, ps;
    wire_out = strobe;
    mac_in   = d;
    wr_ready = rdy;
    cm = m_op && (m_occ > 0) && rdy;
    ps = m_op && m_collect && strobe;
    if (ps) begin
      if (m_occ < 4 || cm) begin
        exp_q.push_back('{addr: ADDR_W'(m_acc), data: d});
        m_acc++;
        m_occ++;
      end else begin
        m_drops++;
      end
      m_cap++;
      if (m_cap == N) m_collect = 0;
    end
    if (cm) begin
      m_occ--;
      m_commits++;
    end
    m_last_commit = cm;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_op();
    start = 1'b1;
    cycle(1'b0, '0, 1'b0);
    chk("busy_after_start", busy, 1);
    chk("count_cleared", result_count, 0);
    m_op = 1; m_collect = 1;
    m_cap = 0; m_occ = 0; m_acc = 0; m_commits = 0; m_drops = 0;
  endtask

  task automatic fill_rest(input bit always_ready);
    while (m_collect) begin
      cycle(($urandom % 3) == 0, DATA_W'($urandom), always_ready || (($urandom % 4) != 0));
    end
  endtask

  // Runs until the final commit, then checks the two-cycle done timing.
  task automatic finish_op();
    bit hit = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (m_last_commit && m_commits == m_acc) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      errors++;
      checks++;
      $display("FAIL finish_op_timeout: got no final commit expected one within 200 cycles");
    end
    chk("done_low_in_drain", done, 0);
    chk("busy_in_drain", busy, 1);
    cycle(1'b0, '0, 1'b1);
    chk("done_two_after_last", done, 1);
    chk("busy_low_in_done", busy, 0);
    chk("final_count", result_count, N - m_drops);
    chk("final_overflow", overflow, (m_drops > 0) ? 1 : 0);
  endtask

  task automatic end_op();
    start = 1'b0;
    cycle(1'b0, '0, 1'b1);
    chk("idle_done_low", done, 0);
    chk("idle_busy_low", busy, 0);
    m_op = 0;
  endtask

  // Scoreboard monitor: every committed write must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", wr_addr, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W:0] cnt_snap;
    logic [DATA_W-1:0] held;
    bit hit;

    reset_n = 1'b0; start = 1'b0; wire_out = 1'b0; mac_in = '0; wr_ready = 1'b0;
    m_op = 0; m_collect = 0;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", result_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal: strobe every 8 cycles, RAM always ready.
    begin_op();
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, DATA_W'(32'h100 + i), 1'b1);
      if (i < N - 1) repeat (7) cycle(1'b0, '0, 1'b1);
    end
    finish_op();
    // Strobes in DONE are ignored.
    repeat (3) cycle(1'b1, DATA_W'(32'h7_7777), 1'b1);
    chk("done_spurious_count", result_count, N);
    chk("done_spurious_ovf", overflow, 0);
    chk("done_held_start_high", done, 1);
    end_op();
    // Strobes in IDLE are ignored.
    repeat (3) begin
      cycle(1'b1, DATA_W'(32'h5_5555), 1'b1);
      chk("idle_spurious_wr_en", wr_en, 0);
    end
    chk("idle_spurious_count", result_count, N);
    chk("idle_spurious_ovf", overflow, 0);

    // Backpressure: write port frozen for 20 cycles while 2 results arrive.
    begin_op();
    held = DATA_W'($urandom);
    cycle(1'b1, held, 1'b0);
    for (int j = 0; j < 19; j++) begin
      cycle(j == 4, DATA_W'($urandom), 1'b0);
      chk("bp_wr_en", wr_en, 1);
      chk("bp_wr_addr", wr_addr, 0);
      chk("bp_wr_data", wr_data, held);
    end
    cycle(1'b0, '0, 1'b1);
    chk("bp_second_wr_en", wr_en, 1);
    chk("bp_second_addr", wr_addr, 1);
    cycle(1'b0, '0, 1'b1);
    chk("bp_drained", wr_en, 0);
    fill_rest(1'b0);
    finish_op();
    end_op();

    // Overflow: 6 back-to-back strobes into a stalled port.
    begin_op();
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, DATA_W'(32'h2_0000 + j), 1'b0);
      if (j == 3) chk("ovf_after_4", overflow, 0);
      if (j == 4) chk("ovf_after_5", overflow, 1);
    end
    fill_rest(1'b1);
    finish_op();
    chk("ovf_count_n_minus_2", result_count, N - 2);
    end_op();

    // Full FIFO with simultaneous push and pop keeps occupancy at 4.
    begin_op();
    for (int j = 0; j < 4; j++) cycle(1'b1, DATA_W'(32'h3_0000 + j), 1'b0);
    cycle(1'b1, DATA_W'(32'h3_0004), 1'b1);
    chk("full_pushpop_no_ovf", overflow, 0);
    cycle(1'b1, DATA_W'(32'h3_0005), 1'b0);
    chk("full_still_4_drops", overflow, 1);
    fill_rest(1'b1);
    finish_op();
    chk("full_count_n_minus_1", result_count, N - 1);
    end_op();

    // Reset in the middle of an operation, then a fresh run from address 0.
    begin_op();
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, DATA_W'($urandom), 1'b1);
      cycle(1'b0, '0, 1'b1);
      if (m_commits >= 10) begin
        hit = 1;
        break;
      end
    end
    chk("midrst_reached_10", hit, 1);
    cnt_snap = result_count;
    chk("midrst_count_before", cnt_snap, 10);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_count", result_count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_overflow", overflow, 0);
    exp_q.delete();
    m_op = 0; m_collect = 0;
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    begin_op();
    fill_rest(1'b0);
    finish_op();
    end_op();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_result_writer.md
# mat_result_writer

Result-side companion to the matrix-multiply controller. It captures each MAC result when the controller pulses its result strobe, buffers results in a 4-entry FIFO, and writes them to consecutive addresses of the result RAM through a write port with backpressure. It reports `done` once all `N_RESULTS` results are committed, using the same start/done handshake as the controller.

## Interface

Parameters:
- `DATA_W`, 19: MAC result width.
- `ADDR_W`, 5: result RAM address width.
- `N_RESULTS`, 32: results per operation; must satisfy 1 ≤ N_RESULTS ≤ 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level. Begins a collection when sampled high in IDLE.
- `wire_out`, in, 1: one-cycle result strobe from the controller.
- `mac_in`, in, DATA_W: MAC result, valid in the cycle `wire_out` is high.
- `wr_ready`, in, 1: RAM accepts a write this cycle.
- `wr_en`, out, 1: write request.
- `wr_addr`, out, ADDR_W: write address.
- `wr_data`, out, DATA_W: write data (FIFO head).
- `result_count`, out, ADDR_W+1: number of writes committed.
- `busy`, out, 1: high in COLLECT or DRAIN.
- `done`, out, 1: high in DONE.
- `overflow`, out, 1: sticky flag, set when a result is dropped.

## Operation

- States:
  - IDLE. If `start`=1, clear `wr_addr`, `result_count`, capture count, `overflow` and the FIFO, then go to COLLECT. Otherwise stay.
  - COLLECT. Each `wire_out`=1 cycle is a push of `mac_in`. When the capture count reaches N_RESULTS, go to DRAIN in the same edge as the last push.
  - DRAIN. Ignore `wire_out`. Go to DONE when the FIFO is empty and no write is pending.
  - DONE. `done`=1. When `start`=0, go to IDLE.
- A write is committed in a cycle where `wr_en`=1 and `wr_ready`=1. On commit: pop the FIFO, increment `wr_addr` and `result_count`.
- `wr_en` = FIFO not empty AND state is COLLECT or DRAIN. `wr_data` is the FIFO head, combinational from FIFO registers. While `wr_en`=1 and `wr_ready`=0, `wr_en`, `wr_addr` and `wr_data` hold stable.
- FIFO: 4 entries, separate pointers plus an occupancy counter (0..4).
  - Full, and push and pop in the same cycle: the push is accepted and occupancy stays 4.
  - Full, and push with no pop: the result is dropped, `overflow` is set, and the capture count still increments so the operation terminates.
- `wire_out` outside COLLECT is ignored and does not affect `overflow`.
- `start` is not sampled in COLLECT or DRAIN. A collection cannot be restarted mid-operation except by reset.
- `wr_addr` range is 0..N_RESULTS-1 and never wraps within an operation. If N_RESULTS = 2^ADDR_W, `wr_addr` wraps to 0 after the final commit, which is harmless.
- After a run with overflow, `result_count` = N_RESULTS minus the number of dropped results.

## Timing

- Reset (`reset_n`=0, asynchronous): state IDLE, FIFO empty. `wr_en`, `wr_addr`, `wr_data`, `result_count`, `busy`, `done` and `overflow` are all 0. Reset mid-operation abandons the run with no further writes.
- `start` sampled high in IDLE at edge k: `busy`=1 from k.
- Push latency: strobe in cycle t with the FIFO empty gives `wr_en`=1 in cycle t+1 with `wr_data`=`mac_in`(t). With `wr_ready`=1, the write commits in t+1.
- Sustained throughput is one write per cycle. With the controller's strobe every 8 cycles and `wr_ready`=1, occupancy never exceeds 1.
- Last commit at edge m (FIFO empty after it): state is DRAIN during cycle m+1 and DONE at edge m+1. `done` rises in cycle m+2, i.e. 2 cycles after the final commit.
- DONE exits to IDLE on the first edge with `start`=0. `done` falls the following cycle.

## Test plan

- Nominal run, N_RESULTS=32: `start`=1; strobe every 8 cycles with `mac_in`=0x100+i and `wr_ready`=1. Expect 32 writes at addresses 0..31 with data 0x100..0x11F. `done`=1 two cycles after the last commit, `result_count`=32, `overflow`=0. Dropping `start` returns the block to IDLE.
- Backpressure: `wr_ready`=0 for 20 cycles while 2 strobes arrive. Expect `wr_en`, `wr_addr`=0 and `wr_data` held stable throughout. On release, writes commit at addresses 0 and 1 on consecutive cycles with no loss.
- Overflow: `wr_ready`=0 and 6 back-to-back strobes. Expect the first 4 buffered, `overflow`=1 after the 5th strobe, and the end state `result_count`=N_RESULTS-2.
- Full with simultaneous push and pop: fill 4 entries, then assert `wr_ready`=1 in the same cycle as a strobe. Expect no overflow, occupancy stays 4, and data order is preserved.
- Reset mid-operation: pull `reset_n` low after 10 commits. Expect all outputs 0 immediately with no clock edge needed. A new `start` then writes from address 0.
- Spurious strobes: `wire_out` pulses in IDLE and DONE. Expect no writes, no count change and `overflow`=0.
